// File: rtl/pcs_pkg.sv
// Shared types and constants for the PCS TX sequencing logic.
package pcs_pkg;

  localparam int PCS_SEQ_W = 6;
  localparam logic [PCS_SEQ_W-1:0] PCS_PAUSE_SEQ = 6'd32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2
  } pcs_state_e;

  // Sync-header placement: 64-bit beats carry a header every beat, 32-bit beats every other beat.
  function automatic logic pcs_hdr_beat(input logic [PCS_SEQ_W-1:0] seq, input logic wide);
    logic hdr;
    if (seq == PCS_PAUSE_SEQ) begin
      hdr = 1'b0;
    end else if (wide) begin
      hdr = 1'b1;
    end else begin
      hdr = ~seq[0];
    end
    return hdr;
  endfunction

endpackage

// File: rtl/pcs_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module pcs_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Count state: holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= {WIDTH{1'b0}};
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/pcs_tx_seq_ctrl.sv
// 64b/66b TX gearbox sequencer: IDLE/ALIGN/RUN control, sequence, header and MAC pause.
// Optional block statistics enabled by defining PCS_TX_STATS_EN.
module pcs_tx_seq_ctrl
  import pcs_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ALIGN_CYCLES = 16
) (
  input  logic                 gty_tx_usr_clk,
  input  logic                 gty_tx_usr_reset,
  input  logic                 i_gty_tx_ready,
  input  logic                 i_xgmii_valid,
  output logic [PCS_SEQ_W-1:0] o_gb_sequence,
  output logic                 o_gb_hdr_beat,
  output logic                 o_xgmii_pause,
  output logic                 o_tx_active,
  output logic [31:0]          o_blk_count
);

  localparam logic       WIDE       = (DATA_WIDTH == 64);
  localparam logic [7:0] ALIGN_LAST = 8'(ALIGN_CYCLES - 1);

  pcs_state_e           state;
  pcs_state_e           state_nxt;
  logic [7:0]           align_cnt;
  logic [7:0]           align_cnt_nxt;
  logic [PCS_SEQ_W-1:0] seq_nxt;
  logic                 run_nxt;

  // Next-state, alignment count and sequence; a ready drop always wins over the wrap.
  always_comb begin
    state_nxt     = state;
    align_cnt_nxt = align_cnt;
    seq_nxt       = o_gb_sequence;
    case (state)
      ST_IDLE: begin
        align_cnt_nxt = 8'd0;
        seq_nxt       = 6'd0;
        if (i_gty_tx_ready) begin
          state_nxt = ST_ALIGN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ALIGN: begin
        seq_nxt = 6'd0;
        if (!i_gty_tx_ready) begin
          state_nxt     = ST_IDLE;
          align_cnt_nxt = 8'd0;
        end else if (align_cnt == ALIGN_LAST) begin
          state_nxt     = ST_RUN;
          align_cnt_nxt = 8'd0;
        end else begin
          state_nxt     = ST_ALIGN;
          align_cnt_nxt = align_cnt + 8'd1;
        end
      end
      ST_RUN: begin
        align_cnt_nxt = 8'd0;
        if (!i_gty_tx_ready) begin
          state_nxt = ST_IDLE;
          seq_nxt   = 6'd0;
        end else if (o_gb_sequence == PCS_PAUSE_SEQ) begin
          state_nxt = ST_RUN;
          seq_nxt   = 6'd0;
        end else begin
          state_nxt = ST_RUN;
          seq_nxt   = o_gb_sequence + 6'd1;
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        align_cnt_nxt = 8'd0;
        seq_nxt       = 6'd0;
      end
    endcase
    run_nxt = (state_nxt == ST_RUN);
  end

  // State and registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge gty_tx_usr_clk) begin
    if (!gty_tx_usr_reset) begin
      state         <= ST_IDLE;
      align_cnt     <= 8'd0;
      o_gb_sequence <= 6'd0;
      o_xgmii_pause <= 1'b1;
      o_gb_hdr_beat <= 1'b0;
      o_tx_active   <= 1'b0;
    end else begin
      state         <= state_nxt;
      align_cnt     <= align_cnt_nxt;
      o_gb_sequence <= seq_nxt;
      o_xgmii_pause <= ~run_nxt | (seq_nxt == PCS_PAUSE_SEQ);
      o_gb_hdr_beat <= run_nxt & pcs_hdr_beat(seq_nxt, WIDE);
      o_tx_active   <= run_nxt;
    end
  end

`ifdef PCS_TX_STATS_EN
  logic blk_inc;

  assign blk_inc = o_tx_active & o_gb_hdr_beat & i_xgmii_valid;

  pcs_sat_counter #(
    .WIDTH(32)
  ) u_blk_cnt (
    .clk   (gty_tx_usr_clk),
    .rst_n (gty_tx_usr_reset),
    .inc   (blk_inc),
    .count (o_blk_count)
  );
`else
  logic unused_valid;

  assign unused_valid = i_xgmii_valid;
  assign o_blk_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pcs_tx_seq_ctrl.sv
// Directed bench for pcs_tx_seq_ctrl (32- and 64-bit instances) and pcs_sat_counter.
module tb_pcs_tx_seq_ctrl;

`ifdef PCS_TX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        ready;
  logic        valid;
  logic [5:0]  seq32, seq64;
  logic        hdr32, hdr64;
  logic        pause32, pause64;
  logic        act32, act64;
  logic [31:0] blk32, blk64;
  logic        sc_rst_n;
  logic        sc_inc;
  logic [1:0]  sc_count;

  int tests = 0;
  int fails = 0;
  int npause = 0;
  int unsigned exp32 = 0;
  int unsigned exp64 = 0;
  logic [31:0] keep32, keep64;

  pcs_tx_seq_ctrl #(.DATA_WIDTH(32), .ALIGN_CYCLES(16)) dut32 (
    .gty_tx_usr_clk(clk), .gty_tx_usr_reset(rst_n), .i_gty_tx_ready(ready),
    .i_xgmii_valid(valid), .o_gb_sequence(seq32), .o_gb_hdr_beat(hdr32),
    .o_xgmii_pause(pause32), .o_tx_active(act32), .o_blk_count(blk32)
  );

  pcs_tx_seq_ctrl #(.DATA_WIDTH(64), .ALIGN_CYCLES(16)) dut64 (
    .gty_tx_usr_clk(clk), .gty_tx_usr_reset(rst_n), .i_gty_tx_ready(ready),
    .i_xgmii_valid(valid), .o_gb_sequence(seq64), .o_gb_hdr_beat(hdr64),
    .o_xgmii_pause(pause64), .o_tx_active(act64), .o_blk_count(blk64)
  );

  pcs_sat_counter #(.WIDTH(2)) u_sc (
    .clk(clk), .rst_n(sc_rst_n), .inc(sc_inc), .count(sc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_hdr(input int s, input bit wide);
    return (s < 32) && (wide || ((s % 2) == 0));
  endfunction

  function automatic logic [31:0] exp_blk(input int unsigned n);
    return STATS ? n : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string ctx, input int s, input logic p, input logic act);
    check({ctx, " seq32"},   32'(seq32),   32'(s));
    check({ctx, " seq64"},   32'(seq64),   32'(s));
    check({ctx, " pause32"}, 32'(pause32), 32'(p));
    check({ctx, " pause64"}, 32'(pause64), 32'(p));
    check({ctx, " hdr32"},   32'(hdr32),   32'(act & exp_hdr(s, 1'b0)));
    check({ctx, " hdr64"},   32'(hdr64),   32'(act & exp_hdr(s, 1'b1)));
    check({ctx, " act32"},   32'(act32),   32'(act));
    check({ctx, " act64"},   32'(act64),   32'(act));
    check({ctx, " blk32"},   blk32,        exp_blk(exp32));
    check({ctx, " blk64"},   blk64,        exp_blk(exp64));
  endtask

  // One RUN cycle: drive valid, check outputs, then account for the block it would count.
  task automatic run_cycle(input string ctx, input int s, input logic v);
    valid = v;
    check_all(ctx, s, (s == 32), 1'b1);
    if (v) begin
      exp32 += 32'(exp_hdr(s, 1'b0));
      exp64 += 32'(exp_hdr(s, 1'b1));
    end
    tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    ready    = 1'b0;
    valid    = 1'b0;
    sc_rst_n = 1'b0;
    sc_inc   = 1'b0;
    @(negedge clk);
    tick();
    tick();
    check_all("reset", 0, 1'b1, 1'b0);

    // Ready from the first post-reset cycle; valid high to show ALIGN does not count blocks.
    rst_n = 1'b1;
    ready = 1'b1;
    valid = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_all("align", 0, 1'b1, 1'b0);
    end
    tick();

    for (int i = 0; i < 100; i++) begin
      if (i == 33) begin
        check("blk32 after one period", blk32, STATS ? 32'd16 : 32'd0);
        check("blk64 after one period", blk64, STATS ? 32'd32 : 32'd0);
      end
      if (pause32) npause++;
      run_cycle("run", i % 33, 1'b1);
    end
    check("pause cycles in 100", 32'(npause), 32'd3);

    for (int j = 1; j <= 31; j++) begin
      run_cycle("gated", j, ((j % 3) != 0));
    end
    valid = 1'b1;
    check_all("seq32", 32, 1'b1, 1'b1);
    keep32 = blk32;
    keep64 = blk64;
    ready = 1'b0;
    tick();
    check_all("drop", 0, 1'b1, 1'b0);
    check("drop blk32 held", blk32, keep32);
    check("drop blk64 held", blk64, keep64);

    // Abort alignment at count 10, then a full 16-cycle alignment is needed again.
    ready = 1'b1;
    tick();
    check_all("realign", 0, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) tick();
    ready = 1'b0;
    tick();
    check_all("abort", 0, 1'b1, 1'b0);
    ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_all("align2", 0, 1'b1, 1'b0);
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      run_cycle("run2", i, 1'b1);
    end

    rst_n = 1'b0;
    tick();
    exp32 = 0;
    exp64 = 0;
    check_all("midrst", 0, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick();
    check_all("postrst", 0, 1'b1, 1'b0);

    tick();
    check("sc reset", 32'(sc_count), 32'd0);
    sc_rst_n = 1'b1;
    sc_inc   = 1'b1;
    tick();
    check("sc one", 32'(sc_count), 32'd1);
    tick();
    check("sc two", 32'(sc_count), 32'd2);
    tick();
    check("sc max", 32'(sc_count), 32'd3);
    tick();
    tick();
    check("sc saturate", 32'(sc_count), 32'd3);
    sc_inc = 1'b0;
    tick();
    check("sc hold", 32'(sc_count), 32'd3);
    sc_rst_n = 1'b0;
    tick();
    check("sc clear", 32'(sc_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
